// File: rtl/adc_frontend_if.sv
// Host/controller-facing bundle of the ADC front end: UART byte feed,
// select/clear command handshakes, external ADC port, sample output and
// sample-RAM write port.
interface adc_frontend_if #(
  parameter int WIDTH        = 12,
  parameter int SAMPLE_DEPTH = 8
);
  logic [7:0]              rx_data;
  logic                    rx_ready;
  logic                    sel_activate;
  logic                    sel_done;
  logic                    clr_activate;
  logic                    clr_done;
  logic [WIDTH-1:0]        ext_adc_data;
  logic                    ext_adc_clk;
  logic [WIDTH-1:0]        adc_data;
  logic                    adc_clk;
  logic [SAMPLE_DEPTH-1:0] mem_addr;
  logic [WIDTH-1:0]        mem_data;
  logic                    mem_we;

  // front end side
  modport slave (
    input  rx_data, rx_ready, sel_activate, clr_activate, ext_adc_data,
    output sel_done, clr_done, ext_adc_clk, adc_data, adc_clk,
           mem_addr, mem_data, mem_we
  );

  // controller / environment side
  modport master (
    output rx_data, rx_ready, sel_activate, clr_activate, ext_adc_data,
    input  sel_done, clr_done, ext_adc_clk, adc_data, adc_clk,
           mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/adc_frontend.sv
// ADC acquisition front end: two synthetic triangle sources plus an
// external ADC, a UART-commanded source selector, and a sample-RAM clear
// engine. Both commands use activate/done handshakes.

// Triangle-wave generator. Exposes the value it will hold after the next
// step so the output register can capture the freshly advanced sample.
module adc_tri_gen #(
  parameter int WIDTH = 12,
  parameter int INC   = 1,
  parameter int DEC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [WIDTH-1:0] value_nxt
);
  localparam logic [WIDTH-1:0] MAX   = '1;
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [WIDTH-1:0] DEC_W = WIDTH'(DEC);

  logic [WIDTH-1:0] value;
  logic             up, up_nxt;

  // Next value: the step that lands on a rail also turns around, so the
  // peak and the floor are each emitted exactly once (4090, 4095, 4090).
  always_comb begin
    value_nxt = value;
    up_nxt    = up;
    if (up) begin
      if (value >= MAX - INC_W) begin
        value_nxt = MAX;
        up_nxt    = 1'b0;
      end else begin
        value_nxt = value + INC_W;
      end
    end else begin
      if (value <= DEC_W) begin
        value_nxt = '0;
        up_nxt    = 1'b1;
      end else begin
        value_nxt = value - DEC_W;
      end
    end
  end

  // Advance on every sample tick
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      up    <= 1'b1;
    end else if (step) begin
      value <= value_nxt;
      up    <= up_nxt;
    end
  end
endmodule

module adc_frontend #(
  parameter int WIDTH        = 12,
  parameter int SAMPLE_DEPTH = 8,
  parameter int DIV          = 4,
  parameter int INC1         = 1,
  parameter int DEC1         = 1,
  parameter int INC2         = 5,
  parameter int DEC2         = 5
) (
  input  logic           clk,
  input  logic           rst,
  adc_frontend_if.slave  bus
);
  typedef enum logic [1:0] {SRC1 = 2'd1, SRC2 = 2'd2, SRC_EXT = 2'd3} src_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} sel_st_e;
  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_FILL, C_DONE} clr_st_e;

  localparam int                      CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]           TICK_LAST = CW'(DIV - 1);
  localparam logic [SAMPLE_DEPTH-1:0] ADDR_LAST = '1;

  logic [CW-1:0]           tick_cnt;
  logic                    tick;
  logic [WIDTH-1:0]        src1_nxt, src2_nxt;
  src_e                    sel;
  sel_st_e                 sel_st;
  clr_st_e                 clr_st;
  logic                    sel_done_q, clr_done_q;
  logic [WIDTH-1:0]        adc_data_q;
  logic                    adc_clk_q, ext_clk_q;
  logic [SAMPLE_DEPTH-1:0] fill_addr;
  logic [WIDTH-1:0]        fill_val;
  logic                    we;

  assign tick = (tick_cnt == TICK_LAST);

  // Sample tick divider: one tick every DIV clocks, held at 0 in reset
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + CW'(1);
  end

  adc_tri_gen #(.WIDTH(WIDTH), .INC(INC1), .DEC(DEC1)) u_gen1 (
    .clk(clk), .rst(rst), .step(tick), .value_nxt(src1_nxt)
  );

  adc_tri_gen #(.WIDTH(WIDTH), .INC(INC2), .DEC(DEC2)) u_gen2 (
    .clk(clk), .rst(rst), .step(tick), .value_nxt(src2_nxt)
  );

  // Sample register: capture the selected source on tick, strobe next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_data_q <= '0;
      adc_clk_q  <= 1'b0;
      ext_clk_q  <= 1'b0;
    end else begin
      adc_clk_q <= tick;
      ext_clk_q <= tick && (sel == SRC_EXT);
      if (tick) begin
        case (sel)
          SRC1:    adc_data_q <= src1_nxt;
          SRC2:    adc_data_q <= src2_nxt;
          default: adc_data_q <= bus.ext_adc_data;
        endcase
      end
    end
  end

  // Select FSM: wait for one UART byte, decode it, hold done until release
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_st     <= S_IDLE;
      sel        <= SRC1;
      sel_done_q <= 1'b0;
    end else begin
      case (sel_st)
        S_IDLE: if (bus.sel_activate) sel_st <= S_WAIT;
        S_WAIT: begin
          if (!bus.sel_activate) begin
            sel_st <= S_IDLE;
          end else if (bus.rx_ready) begin
            case (bus.rx_data)
              8'h01:   sel <= SRC1;
              8'h02:   sel <= SRC2;
              8'h03:   sel <= SRC_EXT;
              default: ;
            endcase
            sel_st     <= S_DONE;
            sel_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.sel_activate) begin
            sel_st     <= S_IDLE;
            sel_done_q <= 1'b0;
          end
        end
        default: begin
          sel_st     <= S_IDLE;
          sel_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Clear FSM: latch fill byte, sweep every RAM address once, then done
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_st     <= C_IDLE;
      fill_addr  <= '0;
      fill_val   <= '0;
      clr_done_q <= 1'b0;
    end else begin
      case (clr_st)
        C_IDLE: if (bus.clr_activate) clr_st <= C_WAIT;
        C_WAIT: begin
          if (!bus.clr_activate) begin
            clr_st <= C_IDLE;
          end else if (bus.rx_ready) begin
            fill_val  <= WIDTH'(bus.rx_data);
            fill_addr <= '0;
            clr_st    <= C_FILL;
          end
        end
        C_FILL: begin
          if (!bus.clr_activate) begin
            clr_st <= C_IDLE;
          end else if (fill_addr == ADDR_LAST) begin
            clr_st     <= C_DONE;
            clr_done_q <= 1'b1;
          end else begin
            fill_addr <= fill_addr + SAMPLE_DEPTH'(1);
          end
        end
        C_DONE: begin
          if (!bus.clr_activate) begin
            clr_st     <= C_IDLE;
            clr_done_q <= 1'b0;
          end
        end
        default: begin
          clr_st     <= C_IDLE;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Write enable is gated combinationally so an abort (activate low) or a
  // reset kills the write in the very cycle it is seen.
  assign we = (clr_st == C_FILL) && bus.clr_activate && !rst;

  assign bus.mem_we      = we;
  assign bus.mem_addr    = we ? fill_addr : '0;
  assign bus.mem_data    = we ? fill_val  : '0;
  assign bus.adc_data    = adc_data_q;
  assign bus.adc_clk     = adc_clk_q;
  assign bus.ext_adc_clk = ext_clk_q;
  assign bus.sel_done    = sel_done_q;
  assign bus.clr_done    = clr_done_q;
endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend: source selection, triangle turnarounds,
// external ADC path, memory clear with completion / abort / reset.
module tb_adc_frontend;
  localparam int W = 12;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  adc_frontend_if #(.WIDTH(W), .SAMPLE_DEPTH(D)) bus ();

  adc_frontend #(
    .WIDTH(W), .SAMPLE_DEPTH(D), .DIV(4),
    .INC1(1), .DEC1(1), .INC2(5), .DEC2(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Pulse monitor: counts adc_clk strobes since reset and clocks between them
  int          nt = 0;
  int          gap = 0;
  int          last_gap = 0;
  logic [W-1:0] last_d = '0;
  logic        last_ext = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      nt  = 0;
      gap = 0;
    end else begin
      gap++;
      if (bus.adc_clk) begin
        nt++;
        last_d   = bus.adc_data;
        last_ext = bus.ext_adc_clk;
        last_gap = gap;
        gap      = 0;
      end
    end
  end

  task automatic wait_pulse(output logic [W-1:0] d, output int n, output logic ext);
    int n0 = nt;
    int k  = 0;
    while (nt == n0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    if (nt == n0) chk("pulse_timeout", 0, 1);
    d   = last_d;
    n   = nt;
    ext = last_ext;
    chk("tick_gap", last_gap, 4);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic do_select(input logic [7:0] b);
    @(negedge clk);
    bus.sel_activate = 1'b1;
    repeat (2) @(negedge clk);
    chk("sel_done_wait", bus.sel_done, 0);
    rx_byte(b);
    chk("sel_done", bus.sel_done, 1);
  endtask

  task automatic sel_release();
    bus.sel_activate = 1'b0;
    @(negedge clk);
    chk("sel_done_drop", bus.sel_done, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_adc_data"}, bus.adc_data, 0);
    chk({tag, "_adc_clk"},  bus.adc_clk, 0);
    chk({tag, "_ext_clk"},  bus.ext_adc_clk, 0);
    chk({tag, "_sel_done"}, bus.sel_done, 0);
    chk({tag, "_clr_done"}, bus.clr_done, 0);
    chk({tag, "_mem_we"},   bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_data"}, bus.mem_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    int           n, wr, k, k_last, extra, guard;
    logic         e;

    bus.rx_data      = '0;
    bus.rx_ready     = 1'b0;
    bus.sel_activate = 1'b0;
    bus.clr_activate = 1'b0;
    bus.ext_adc_data = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // source 1 ramps 1..8, first strobe DIV clocks after release
    for (int i = 1; i <= 8; i++) begin
      wait_pulse(d, n, e);
      chk("src1_n", n, i);
      chk("src1_data", d, i);
      chk("src1_ext_clk", e, 0);
    end

    // byte while idle does not change the selection
    rx_byte(8'h02);
    wait_pulse(d, n, e);
    chk("rx_idle_ignored", d, n);

    // source 2: multiples of 5
    do_select(8'h02);
    for (int i = 0; i < 3; i++) begin
      wait_pulse(d, n, e);
      chk("src2_data", d, 5 * n);
      chk("src2_ext_clk", e, 0);
    end
    sel_release();

    // external source
    bus.ext_adc_data = 12'hA5C;
    do_select(8'h03);
    for (int i = 0; i < 2; i++) begin
      wait_pulse(d, n, e);
      chk("ext_data", d, 12'hA5C);
      chk("ext_clk", e, 1);
    end
    sel_release();

    // invalid code keeps external selected
    do_select(8'h07);
    wait_pulse(d, n, e);
    chk("bad_code_data", d, 12'hA5C);
    chk("bad_code_ext_clk", e, 1);
    bus.ext_adc_data = 12'h123;
    wait_pulse(d, n, e);
    chk("ext_resample", d, 12'h123);
    sel_release();

    // activate dropped in WAIT: no done, later byte ignored
    @(negedge clk);
    bus.sel_activate = 1'b1;
    repeat (2) @(negedge clk);
    bus.sel_activate = 1'b0;
    @(negedge clk);
    rx_byte(8'h01);
    chk("sel_abort_done", bus.sel_done, 0);
    wait_pulse(d, n, e);
    chk("sel_abort_keep", d, 12'h123);
    chk("sel_abort_ext_clk", e, 1);

    // source 2 through the top and back to the bottom
    do_select(8'h02);
    sel_release();
    guard = 0;
    while (nt < 1640 && guard < 2000) begin
      wait_pulse(d, n, e);
      guard++;
      case (n)
        817:  chk("top_4085", d, 4085);
        818:  chk("top_4090", d, 4090);
        819:  chk("top_4095", d, 4095);
        820:  chk("top_down_4090", d, 4090);
        821:  chk("top_down_4085", d, 4085);
        1637: chk("bot_5", d, 5);
        1638: chk("bot_0", d, 0);
        1639: chk("bot_up_5", d, 5);
        default: ;
      endcase
    end

    // full clear with 0x3C
    @(negedge clk);
    bus.clr_activate = 1'b1;
    repeat (2) @(negedge clk);
    chk("clr_wait_we", bus.mem_we, 0);
    rx_byte(8'h3C);
    wr = 0; k = 0; k_last = -10;
    while (!bus.clr_done && k < 300) begin
      if (bus.mem_we) begin
        chk("fill_addr", bus.mem_addr, wr);
        chk("fill_data", bus.mem_data, 12'h03C);
        wr++;
        k_last = k;
      end
      @(negedge clk);
      k++;
    end
    chk("fill_count", wr, 256);
    chk("clr_done", bus.clr_done, 1);
    chk("done_after_last", k - k_last, 1);
    extra = 0;
    repeat (5) begin
      extra += int'(bus.mem_we);
      @(negedge clk);
    end
    chk("no_write_after_done", extra, 0);
    bus.clr_activate = 1'b0;
    @(negedge clk);
    chk("clr_done_drop", bus.clr_done, 0);

    // abort at address 0x40
    bus.clr_activate = 1'b1;
    repeat (2) @(negedge clk);
    rx_byte(8'h55);
    k = 0;
    while (!(bus.mem_we && bus.mem_addr == 8'h40) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_40", bus.mem_addr, 8'h40);
    bus.clr_activate = 1'b0;
    #1;
    chk("abort_we", bus.mem_we, 0);
    chk("abort_addr", bus.mem_addr, 0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      extra += int'(bus.clr_done) + int'(bus.mem_we);
    end
    chk("abort_quiet", extra, 0);

    // one byte consumed by both FSMs in WAIT
    @(negedge clk);
    bus.clr_activate = 1'b1;
    bus.sel_activate = 1'b1;
    repeat (2) @(negedge clk);
    rx_byte(8'h01);
    chk("both_sel_done", bus.sel_done, 1);
    chk("both_we", bus.mem_we, 1);
    chk("both_fill", bus.mem_data, 1);
    bus.clr_activate = 1'b0;
    sel_release();
    wait_pulse(d, n, e);
    chk("both_src1", d, n);

    // reset in the middle of a fill, with source 2 selected
    do_select(8'h02);
    sel_release();
    bus.clr_activate = 1'b1;
    repeat (2) @(negedge clk);
    rx_byte(8'h77);
    k = 0;
    while (bus.mem_addr != 8'h10 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_10", bus.mem_data, 12'h077);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    bus.clr_activate = 1'b0;
    rst = 1'b0;
    wait_pulse(d, n, e);
    chk("post_rst_n", n, 1);
    chk("post_rst_src1", d, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
